// File: rtl/sdm_dac.sv
// Volume-scaling stage plus first-order delta-sigma DAC modulator.
// Define SDM_DITHER_EN to add 2-bit LFSR dither ahead of the modulator accumulator.
module sdm_dac (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic signed [13:0] wave_i,
  input  logic [3:0]         volume_i,
  output logic               busy_o,
  output logic signed [13:0] sample_o,
  output logic               sample_valid_o,
  output logic               overrun_o,
  output logic               dac_o
);

  typedef enum logic [1:0] {StIdle, StScale, StLoad} state_e;

  state_e state_q, state_d;

  logic [1:0]         bit_cnt_q;
  logic signed [13:0] wave_q;
  logic [3:0]         vol_q;
  logic signed [17:0] prod_q;
  logic signed [17:0] wave_ext;
  logic signed [13:0] sample_q;
  logic               sample_valid_q;
  logic               overrun_q;
  logic [13:0]        acc_q;
  logic               dac_q;
  logic [13:0]        u;
  logic [13:0]        u_mod;
  logic [14:0]        sum;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_i) state_d = StScale;
      StScale: if (bit_cnt_q == 2'd3) state_d = StLoad;
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o         = (state_q != StIdle);
    sample_o       = sample_q;
    sample_valid_o = sample_valid_q;
    overrun_o      = overrun_q;
    dac_o          = dac_q;
  end

  assign wave_ext = {{4{wave_q[13]}}, wave_q};

  // Shift-and-add multiply, one volume bit per SCALE cycle, LSB first
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q      <= 2'd0;
      wave_q         <= '0;
      vol_q          <= '0;
      prod_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            wave_q    <= wave_i;
            vol_q     <= volume_i;
            bit_cnt_q <= 2'd0;
            prod_q    <= '0;
          end
        end
        StScale: begin
          if (vol_q[bit_cnt_q]) prod_q <= prod_q + (wave_ext <<< bit_cnt_q);
          bit_cnt_q <= bit_cnt_q + 2'd1;
        end
        StLoad: begin
          sample_q       <= prod_q[17:4];
          sample_valid_q <= 1'b1;
        end
        default: ;
      endcase
      if (valid_i && (state_q != StIdle)) overrun_q <= 1'b1;
    end
  end

  // Offset binary: adding 8192 to a 14-bit signed value flips its sign bit
  assign u = {~sample_q[13], sample_q[12:0]};

`ifdef SDM_DITHER_EN
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic signed [15:0] u_dith;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  always_comb begin
    u_dith = $signed({2'b00, u}) + $signed({{14{lfsr_q[1]}}, lfsr_q[1:0]});
    if (u_dith < 16'sd0)          u_mod = 14'd0;
    else if (u_dith > 16'sd16383) u_mod = 14'd16383;
    else                          u_mod = u_dith[13:0];
  end
`else
  assign u_mod = u;
`endif

  assign sum = {1'b0, acc_q} + {1'b0, u_mod};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= sum[13:0];
      dac_q <= sum[14];
    end
  end

endmodule

// File: doc/sdm_dac.md
SDM_DAC -- requirements
Module: sdm_dac

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the only clock; all logic on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port valid_i, input, 1 bit: one-cycle pulse marking a new filtered sample (driven by the SVF ready pulse).
REQ-004 SHALL have port wave_i, input, signed 14 bits: filtered sample, -8192..8191.
REQ-005 SHALL have port volume_i, input, 4 bits unsigned: master volume, 0..15.
REQ-006 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-007 SHALL have port sample_o, output, signed 14 bits: currently held scaled sample.
REQ-008 SHALL have port sample_valid_o, output, 1 bit: one-cycle pulse in the first cycle sample_o shows a new value.
REQ-009 SHALL have port overrun_o, output, 1 bit: sticky flag, set when a sample is dropped.
REQ-010 SHALL have port dac_o, output, 1 bit: first-order delta-sigma bitstream, registered.

Function
REQ-011 SHALL implement an FSM with states IDLE, SCALE and LOAD.
REQ-012 SHALL, in IDLE with valid_i=1, capture wave_i and volume_i and go to SCALE with bit counter 0.
REQ-013 SHALL, in SCALE, compute the product serially, one volume bit per cycle, LSB first, for exactly 4 cycles; then go to LOAD.
REQ-014 SHALL, in LOAD, write scaled = (wave * volume) >>> 4 (18-bit signed product, arithmetic floor shift) into sample_o; then go to IDLE.
REQ-015 SHALL make the scaled result range -7680..7679, so no saturation is needed.
REQ-016 SHALL give accept-to-output latency: valid_i sampled at edge t -> sample_o new and sample_valid_o=1 in cycle t+6 -> busy_o=1 in cycles t+1..t+5.
REQ-017 SHALL ignore valid_i in SCALE or LOAD: the sample is dropped, captured operands are unchanged, and overrun_o is set to 1 and held until reset.
REQ-018 SHALL make a valid_i arriving in the same cycle the FSM returns to IDLE count as accepted.
REQ-019 SHALL run the modulator every clock, independent of the FSM: u = sample_o + 8192 (14-bit unsigned).
REQ-020 SHALL form the modulator sum as sum = {0,acc} + {0,u} (15 bits), then acc <= sum[13:0] and dac_o <= sum[14].
REQ-021 SHALL make the long-run density of ones on dac_o equal u/16384.
REQ-022 SHALL hold the previous sample_o for the modulator until LOAD completes, with no glitch or partial value.

Reset
REQ-023 SHALL, with rst_i=1 at an edge: state=IDLE, bit counter=0, captured operands=0, acc=0, sample_o=0, sample_valid_o=0, busy_o=0, overrun_o=0, dac_o=0.
REQ-024 SHALL treat reset as dominant over all other inputs; reset during SCALE or LOAD abandons the sample with no sample_valid_o pulse.
REQ-025 SHALL assert no outputs other than their reset values in the first cycle after reset.

Configuration
REQ-026 SHALL gate the dither feature on macro SDM_DITHER_EN.
REQ-027 SHALL, with SDM_DITHER_EN defined: step a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) every clock, seeded 16'hACE1 at reset.
REQ-028 SHALL, with SDM_DITHER_EN defined: add lfsr[1:0], read as signed -2..+1, to u before accumulation, saturating u to 0..16383.
REQ-029 SHALL, with SDM_DITHER_EN undefined: contain no LFSR, use u undithered, and make dac_o bit-exact to REQ-020.

Verification
REQ-030 SHALL cover: reset, then hold with no valid_i -> u=8192, dac_o = 0,1,0,1... starting with 0 in the first cycle after reset (no dither).
REQ-031 SHALL cover: valid_i with wave_i=8191, volume_i=15 -> sample_o=7679 with sample_valid_o at t+6; busy_o high t+1..t+5.
REQ-032 SHALL cover: wave_i=-8192 with volume 15 -> -7680; wave_i=-1 with volume 1 -> -1; any wave with volume 0 -> 0.
REQ-033 SHALL cover: second valid_i at t+3 -> sample dropped, overrun_o=1 from t+4 until reset, result equals the first sample.
REQ-034 SHALL cover: rst_i asserted at t+3 of a scale -> sample_o=0, no sample_valid_o, state IDLE, overrun_o=0.
REQ-035 SHALL cover: sample_o=7679 held for 16384 cycles -> 15871 ones on dac_o (no dither); with SDM_DITHER_EN, count within +/-3 of 15871.
